// File: rtl/freq_div_core_pkg.sv
// Shared constants for the divisor selector and the programmable frequency divider.
// Divisor values are half-periods in clk cycles at CLK_HZ.
package freq_div_core_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned CLK_HZ    = 50_000_000;

    localparam logic [DIV_WIDTH-1:0] DIV_100HZ = 32'd250000;
    localparam logic [DIV_WIDTH-1:0] DIV_200HZ = 32'd125000;
    localparam logic [DIV_WIDTH-1:0] DIV_300HZ = 32'd83333;
    localparam logic [DIV_WIDTH-1:0] DIV_400HZ = 32'd62500;

    // What the divider does on a given clk edge, in priority order.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_RESTART = 2'd1,
        ACT_COUNT   = 2'd2,
        ACT_WRAP    = 2'd3
    } divAction_e;

endpackage

// File: rtl/freq_div_core_if.sv
// Control and status bundle between the divisor selector (master) and the divider core (slave).
interface freq_div_core_if #(
    parameter int unsigned WIDTH = freq_div_core_pkg::DIV_WIDTH
);
    logic             en;
    logic             restart;
    logic [WIDTH-1:0] DivN;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] div_active;
    logic             div_pending;

    modport master (
        output en, restart, DivN,
        input  clk_out, tick, div_active, div_pending
    );

    modport slave (
        input  en, restart, DivN,
        output clk_out, tick, div_active, div_pending
    );
endinterface

// File: rtl/freq_div_core.sv
// Programmable 50%-duty clock divider: DivN is the half-period; a new divisor is only
// adopted at a half-period boundary so clk_out never glitches.
module freq_div_core
    import freq_div_core_pkg::*;
#(
    parameter int unsigned      WIDTH     = DIV_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(DIV_100HZ)
) (
    input  logic          clk,
    input  logic          rst_n,
    freq_div_core_if.slave bus
);

    localparam logic [WIDTH-1:0] ZERO         = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RESET_ACTIVE = (RESET_DIV == ZERO) ? ONE : RESET_DIV;

    function automatic logic [WIDTH-1:0] clampDiv(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        if (x == ZERO) begin
            y = ONE;
        end else begin
            y = x;
        end
        return y;
    endfunction

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic             clkOut_r;
    logic             clkOut_s;
    logic             tick_r;
    logic             tick_s;
    logic [WIDTH-1:0] divActive_r;
    logic [WIDTH-1:0] divActive_s;
    logic [WIDTH-1:0] reqDiv_s;
    logic             atBoundary_s;
    divAction_e       action_s;

    assign reqDiv_s = clampDiv(bus.DivN);
    // divActive_r is never zero, so the subtraction cannot wrap.
    assign atBoundary_s = (cnt_r == (divActive_r - ONE));

    // Decode this edge's action: restart beats enable.
    always_comb begin
        action_s = ACT_HOLD;
        if (bus.restart) begin
            action_s = ACT_RESTART;
        end else if (bus.en) begin
            if (atBoundary_s) begin
                action_s = ACT_WRAP;
            end else begin
                action_s = ACT_COUNT;
            end
        end else begin
            action_s = ACT_HOLD;
        end
    end

    // Next-state for counter, output phase, tick and active divisor.
    always_comb begin
        cnt_s       = cnt_r;
        clkOut_s    = clkOut_r;
        tick_s      = 1'b0;
        divActive_s = divActive_r;
        case (action_s)
            ACT_RESTART: begin
                cnt_s       = ZERO;
                clkOut_s    = 1'b0;
                divActive_s = reqDiv_s;
            end
            ACT_COUNT: begin
                cnt_s = cnt_r + ONE;
            end
            ACT_WRAP: begin
                cnt_s       = ZERO;
                clkOut_s    = ~clkOut_r;
                tick_s      = 1'b1;
                divActive_s = reqDiv_s;
            end
            ACT_HOLD: begin
                cnt_s = cnt_r;
            end
            default: begin
                cnt_s = cnt_r;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= ZERO;
            clkOut_r    <= 1'b0;
            tick_r      <= 1'b0;
            divActive_r <= RESET_ACTIVE;
        end else begin
            cnt_r       <= cnt_s;
            clkOut_r    <= clkOut_s;
            tick_r      <= tick_s;
            divActive_r <= divActive_s;
        end
    end

    assign bus.clk_out     = clkOut_r;
    assign bus.tick        = tick_r;
    assign bus.div_active  = divActive_r;
    assign bus.div_pending = (reqDiv_s != divActive_r);

endmodule

// File: tb/tb_freq_div_core.sv
// Table-driven bench for freq_div_core: each vector is one clk edge of stimulus plus the
// outputs expected after it; expectations go through a scoreboard queue.
module tb_freq_div_core;
    import freq_div_core_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;

    freq_div_core_if #(.WIDTH(W)) bus ();

    freq_div_core #(.WIDTH(W), .RESET_DIV(32'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic         restart;
        logic [W-1:0] divN;
        logic         tick;
        logic         clkOut;
        logic [W-1:0] div;
        logic         pend;
    } vec_t;

    typedef struct {
        int           idx;
        logic         tick;
        logic         clkOut;
        logic [W-1:0] div;
        logic         pend;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void addVec(input logic e, input logic r, input logic [W-1:0] d,
                                   input logic t, input logic c, input logic [W-1:0] a,
                                   input logic p);
        vec_t v;
        v.en = e; v.restart = r; v.divN = d;
        v.tick = t; v.clkOut = c; v.div = a; v.pend = p;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic checkOutputs(input string tag, input logic t, input logic c,
                                input logic [W-1:0] a, input logic p);
        check({tag, ".tick"}, W'(bus.tick), W'(t));
        check({tag, ".clk_out"}, W'(bus.clk_out), W'(c));
        check({tag, ".div_active"}, bus.div_active, a);
        check({tag, ".div_pending"}, W'(bus.div_pending), W'(p));
    endtask

    task automatic runVecs(input int first, input int last);
        exp_t e;
        for (int i = first; i <= last; i++) begin
            bus.en      = vecs[i].en;
            bus.restart = vecs[i].restart;
            bus.DivN    = vecs[i].divN;
            e.idx = i; e.tick = vecs[i].tick; e.clkOut = vecs[i].clkOut;
            e.div = vecs[i].div; e.pend = vecs[i].pend;
            expQ.push_back(e);
            @(posedge clk);
            #1;
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard: queue empty at vector %0d", i);
            end else begin
                e = expQ.pop_front();
                checkOutputs($sformatf("vec%0d", e.idx), e.tick, e.clkOut, e.div, e.pend);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int segEnd;

        // Steady count with DivN=4: ticks on edges 4, 8, 12 (vectors 0..11).
        for (int k = 1; k <= 12; k++) begin
            addVec(1'b1, 1'b0, 32'd4, (k % 4) == 0, ((k / 4) % 2) == 1, 32'd4, 1'b0);
        end
        // Divisor change 4->2 at cnt=1, then multiple changes within one half-period.
        addVec(1'b1, 1'b0, 32'd4, 1'b0, 1'b1, 32'd4, 1'b0);
        addVec(1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 32'd4, 1'b1);
        addVec(1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 32'd4, 1'b1);
        addVec(1'b1, 1'b0, 32'd2, 1'b1, 1'b0, 32'd2, 1'b0);
        addVec(1'b1, 1'b0, 32'd2, 1'b0, 1'b0, 32'd2, 1'b0);
        addVec(1'b1, 1'b0, 32'd2, 1'b1, 1'b1, 32'd2, 1'b0);
        addVec(1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 32'd2, 1'b0);
        addVec(1'b1, 1'b0, 32'd2, 1'b1, 1'b0, 32'd2, 1'b0);
        addVec(1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 32'd2, 1'b1);
        addVec(1'b1, 1'b0, 32'd3, 1'b1, 1'b1, 32'd3, 1'b0);
        addVec(1'b1, 1'b0, 32'd4, 1'b0, 1'b1, 32'd3, 1'b1);
        addVec(1'b1, 1'b0, 32'd4, 1'b0, 1'b1, 32'd3, 1'b1);
        addVec(1'b1, 1'b0, 32'd4, 1'b1, 1'b0, 32'd4, 1'b0);
        // Enable gating at cnt=2 for 5 cycles; DivN wiggles but must not be adopted.
        addVec(1'b1, 1'b0, 32'd4, 1'b0, 1'b0, 32'd4, 1'b0);
        addVec(1'b1, 1'b0, 32'd4, 1'b0, 1'b0, 32'd4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            addVec(1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 32'd4, 1'b1);
        end
        addVec(1'b1, 1'b0, 32'd4, 1'b0, 1'b0, 32'd4, 1'b0);
        addVec(1'b1, 1'b0, 32'd4, 1'b1, 1'b1, 32'd4, 1'b0);
        // Restart with en low while clk_out=1, then first tick 3 edges later.
        addVec(1'b1, 1'b0, 32'd4, 1'b0, 1'b1, 32'd4, 1'b0);
        addVec(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0);
        addVec(1'b1, 1'b0, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0);
        addVec(1'b1, 1'b0, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0);
        addVec(1'b1, 1'b0, 32'd3, 1'b1, 1'b1, 32'd3, 1'b0);
        // Clamp: DivN=0 behaves as 1 (clk/2), DivN=1 identical with no pending.
        addVec(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 32'd1, 1'b0);
        addVec(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd1, 1'b0);
        addVec(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0);
        addVec(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd1, 1'b0);
        addVec(1'b1, 1'b0, 32'd1, 1'b1, 1'b0, 32'd1, 1'b0);
        addVec(1'b1, 1'b0, 32'd1, 1'b1, 1'b1, 32'd1, 1'b0);
        // Maximum divisor is accepted as-is.
        addVec(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        addVec(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        addVec(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        addVec(1'b0, 1'b0, 32'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        // Set up cnt=2, clk_out=1 with div_active=5 ahead of the async reset.
        addVec(1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 32'd5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            addVec(1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 32'd5, 1'b0);
        end
        addVec(1'b1, 1'b0, 32'd5, 1'b1, 1'b1, 32'd5, 1'b0);
        addVec(1'b1, 1'b0, 32'd5, 1'b0, 1'b1, 32'd5, 1'b0);
        addVec(1'b1, 1'b0, 32'd5, 1'b0, 1'b1, 32'd5, 1'b0);
        segEnd = vecs.size();
        // After reset release: counting restarts from zero with the reset divisor.
        for (int k = 1; k <= 4; k++) begin
            addVec(1'b1, 1'b0, 32'd4, k == 4, k == 4, 32'd4, 1'b0);
        end

        rst_n       = 1'b1;
        bus.en      = 1'b1;
        bus.restart = 1'b0;
        bus.DivN    = 32'd4;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutputs("reset", 1'b0, 1'b0, 32'd4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        runVecs(0, segEnd - 1);

        // Asynchronous reset between edges, mid half-period.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutputs("asyncRst", 1'b0, 1'b0, 32'd4, 1'b1);
        bus.DivN = 32'd4;
        @(negedge clk);
        rst_n = 1'b1;

        runVecs(segEnd, vecs.size() - 1);

        // Reset straight after a boundary edge clears the live tick too.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutputs("asyncRstTick", 1'b0, 1'b0, 32'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
